// File: rtl/gauss_kernel_gen.sv
// Gaussian kernel generator: fixed-point power table, then a raster
// fill that streams each coefficient and builds the flat kernel and sum.
module gauss_kernel_gen #(
    parameter int MAX_SIZE = 7,
    parameter int COEF_W   = 8,
    parameter int SUM_W    = 32
) (
    input  logic                                 clk,
    input  logic                                 n_rst,
    input  logic                                 start,
    input  logic [3:0]                           size,
    input  logic [2:0]                           sigma,
    input  logic                                 coef_ready,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 coef_valid,
    output logic [COEF_W-1:0]                    coef_data,
    output logic [3:0]                           coef_x,
    output logic [3:0]                           coef_y,
    output logic [MAX_SIZE*MAX_SIZE*COEF_W-1:0]  kernel,
    output logic [SUM_W-1:0]                     sum,
    output logic [3:0]                           kernel_size
);

    localparam int HMAX = (MAX_SIZE - 1) / 2;
    localparam int DMAX = 2 * HMAX * HMAX;
    localparam int IW   = $clog2(DMAX + 1);
    localparam int KW   = MAX_SIZE * MAX_SIZE * COEF_W;
    localparam int KAW  = $clog2(KW);

    typedef enum logic [1:0] {IDLE, POW, FILL, DONE} state_t;

    state_t                state_q;
    logic                  busy_q, done_q, valid_q;
    logic [3:0]            s_q;
    logic [2:0]            h_q;
    logic [IW-1:0]         d_q, cnt_q;
    logic [15:0]           r_q;
    logic [3:0]            x_q, y_q;
    logic [KW-1:0]         kernel_q;
    logic [SUM_W-1:0]      sum_q;
    logic [15:0]           p_q [DMAX+1];

    logic [3:0]            sz_c, s_eff;
    logic [2:0]            h_eff;
    logic [IW-1:0]         d_eff;
    logic [IW-1:0]         prev_idx;
    logic [31:0]           prod;
    logic [15:0]           p_next;
    logic [7:0]            dx, dy;
    logic [IW-1:0]         sq_idx;
    logic [COEF_W-1:0]     coef;
    logic [KAW-1:0]        wr_base;

    // Q0.16 ratio exp(-1/(2*sigma^2)); sigma 0 behaves as sigma 1.
    function automatic logic [15:0] r_of(input logic [2:0] sg);
        logic [15:0] r;
        case (sg)
            3'd0:    r = 16'd39750;
            3'd1:    r = 16'd39750;
            3'd2:    r = 16'd57835;
            3'd3:    r = 16'd61994;
            3'd4:    r = 16'd63520;
            3'd5:    r = 16'd64238;
            3'd6:    r = 16'd64632;
            default: r = 16'd64871;
        endcase
        return r;
    endfunction

    // Clamp the requested size to an odd edge and derive h and 2h^2.
    always_comb begin
        sz_c = size;
        if (size < 4'd3)
            sz_c = 4'd3;
        else if (size > 4'(MAX_SIZE))
            sz_c = 4'(MAX_SIZE);
        s_eff = sz_c[0] ? sz_c : sz_c - 4'd1;
        h_eff = 3'((s_eff - 4'd1) >> 1);
        d_eff = IW'(8'd2 * {5'd0, h_eff} * {5'd0, h_eff});
    end

    // One truncating Q0.16 multiply per POW cycle; radius^2 lookup for FILL.
    always_comb begin
        prev_idx = (cnt_q == '0) ? '0 : cnt_q - IW'(1);
        prod     = 32'(p_q[prev_idx]) * 32'(r_q);
        p_next   = 16'(prod >> 16);
        dx = (x_q >= {1'b0, h_q}) ? 8'(x_q - {1'b0, h_q})
                                  : 8'({1'b0, h_q} - x_q);
        dy = (y_q >= {1'b0, h_q}) ? 8'(y_q - {1'b0, h_q})
                                  : 8'({1'b0, h_q} - y_q);
        sq_idx  = IW'(dx * dx + dy * dy);
        coef    = COEF_W'(p_q[sq_idx] >> (16 - COEF_W));
        wr_base = KAW'((32'(y_q) * MAX_SIZE + 32'(x_q)) * COEF_W);
    end

    // Control FSM with power table, scan counters and kernel storage.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
            s_q      <= '0;
            h_q      <= '0;
            d_q      <= '0;
            r_q      <= '0;
            cnt_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            kernel_q <= '0;
            sum_q    <= '0;
            for (int i = 0; i <= DMAX; i++)
                p_q[i] <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        s_q      <= s_eff;
                        h_q      <= h_eff;
                        d_q      <= d_eff;
                        r_q      <= r_of(sigma);
                        kernel_q <= '0;
                        sum_q    <= '0;
                        p_q[0]   <= 16'hFFFF;
                        cnt_q    <= IW'(1);
                        busy_q   <= 1'b1;
                        state_q  <= POW;
                    end
                end
                POW: begin
                    p_q[cnt_q] <= p_next;
                    if (cnt_q == d_q) begin
                        x_q     <= '0;
                        y_q     <= '0;
                        valid_q <= 1'b1;
                        state_q <= FILL;
                    end else begin
                        cnt_q <= cnt_q + IW'(1);
                    end
                end
                FILL: begin
                    if (coef_ready) begin
                        kernel_q[wr_base +: COEF_W] <= coef;
                        sum_q <= sum_q + SUM_W'(coef);
                        if (x_q == s_q - 4'd1) begin
                            x_q <= '0;
                            if (y_q == s_q - 4'd1) begin
                                y_q     <= '0;
                                valid_q <= 1'b0;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= DONE;
                            end else begin
                                y_q <= y_q + 4'd1;
                            end
                        end else begin
                            x_q <= x_q + 4'd1;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign coef_valid  = valid_q;
    assign coef_data   = valid_q ? coef : '0;
    assign coef_x      = x_q;
    assign coef_y      = y_q;
    assign kernel      = kernel_q;
    assign sum         = sum_q;
    assign kernel_size = s_q;

endmodule

// File: tb/tb_gauss_kernel_gen.sv
// Randomised bench for gauss_kernel_gen against an arithmetic model
// of the Gaussian power recurrence and raster stream.
module tb_gauss_kernel_gen;

    localparam int MS = 7;
    localparam int CW = 8;
    localparam int SW = 32;
    localparam int KW = MS * MS * CW;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          start;
    logic [3:0]    size;
    logic [2:0]    sigma;
    logic          coef_ready;
    logic          busy, done, coef_valid;
    logic [CW-1:0] coef_data;
    logic [3:0]    coef_x, coef_y;
    logic [KW-1:0] kernel;
    logic [SW-1:0] sum;
    logic [3:0]    kernel_size;

    gauss_kernel_gen #(
        .MAX_SIZE(MS), .COEF_W(CW), .SUM_W(SW)
    ) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .size(size),
        .sigma(sigma), .coef_ready(coef_ready), .busy(busy),
        .done(done), .coef_valid(coef_valid), .coef_data(coef_data),
        .coef_x(coef_x), .coef_y(coef_y), .kernel(kernel), .sum(sum),
        .kernel_size(kernel_size)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [511:0] got,
                       input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    int          rtab [7] = '{39750, 57835, 61994, 63520, 64238, 64632, 64871};
    int          m_s, m_h, m_d;
    longint      m_p [0:127];
    logic [KW-1:0] m_k;
    logic [SW-1:0] m_sum;

    function automatic int m_coef(input int x, input int y);
        int r2;
        r2 = (x - m_h) * (x - m_h) + (y - m_h) * (y - m_h);
        return int'(m_p[r2] >> (16 - CW));
    endfunction

    function automatic void model(input int sz, input int sg);
        int s, r, c;
        s = (sz < 3) ? 3 : sz;
        if (s > MS) s = MS;
        if (s % 2 == 0) s = s - 1;
        m_s = s;
        m_h = (s - 1) / 2;
        m_d = 2 * m_h * m_h;
        r = rtab[(sg == 0) ? 0 : sg - 1];
        m_p[0] = 65535;
        for (int k = 1; k <= m_d; k++)
            m_p[k] = (m_p[k-1] * longint'(r)) >> 16;
        m_k = '0;
        m_sum = '0;
        for (int y = 0; y < s; y++)
            for (int x = 0; x < s; x++) begin
                c = m_coef(x, y);
                m_k[(y * MS + x) * CW +: CW] = CW'(c);
                m_sum = m_sum + SW'(c);
            end
    endfunction

    task automatic run(input int sz, input int sg, input int stall_pct,
                       input bit inj, output int done_cyc);
        int cyc, hs, stalls;
        bit prev_stall;
        logic [CW-1:0] pd;
        logic [3:0] px, py;
        model(sz, sg);
        @(negedge clk);
        size = 4'(sz);
        sigma = 3'(sg);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        chk("clr_kernel", 512'(kernel), 512'(0));
        chk("clr_sum", 512'(sum), 512'(0));
        chk("busy_pow", 512'(busy), 512'(1));
        chk("ksize", 512'(kernel_size), 512'(m_s));
        hs = 0;
        stalls = 0;
        prev_stall = 0;
        done_cyc = -1;
        px = '0;
        py = '0;
        pd = '0;
        while (cyc < 2000) begin
            size = 4'($urandom);
            sigma = 3'($urandom);
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (prev_stall) begin
                chk("hold_v", 512'(coef_valid), 512'(1));
                chk("hold_x", 512'(coef_x), 512'(px));
                chk("hold_y", 512'(coef_y), 512'(py));
                chk("hold_d", 512'(coef_data), 512'(pd));
            end
            if (coef_valid) begin
                coef_ready = ($urandom_range(99) >= stall_pct);
                if (coef_ready) begin
                    chk("st_x", 512'(coef_x), 512'(hs % m_s));
                    chk("st_y", 512'(coef_y), 512'(hs / m_s));
                    chk("st_d", 512'(coef_data),
                        512'(m_coef(hs % m_s, hs / m_s)));
                    hs++;
                    prev_stall = 0;
                end else begin
                    stalls++;
                    prev_stall = 1;
                    px = coef_x;
                    py = coef_y;
                    pd = coef_data;
                end
            end else begin
                coef_ready = 1'($urandom_range(1));
            end
            if (inj) start = 1'($urandom_range(1));
            @(negedge clk);
            cyc++;
        end
        if (done_cyc < 0) begin
            chk("timeout", 512'(0), 512'(1));
        end else begin
            chk("done_cyc", 512'(done_cyc),
                512'(1 + m_d + m_s * m_s + stalls));
            chk("hs_count", 512'(hs), 512'(m_s * m_s));
            chk("busy_done", 512'(busy), 512'(0));
            chk("valid_done", 512'(coef_valid), 512'(0));
            chk("kernel", 512'(kernel), 512'(m_k));
            chk("sum", 512'(sum), 512'(m_sum));
            chk("ksize_done", 512'(kernel_size), 512'(m_s));
        end
        start = inj;
        @(negedge clk);
        start = 1'b0;
        coef_ready = 1'b1;
        chk("done_single", 512'(done), 512'(0));
        chk("idle_after", 512'(busy), 512'(0));
    endtask

    task automatic reset_mid_fill();
        bit seen;
        model(7, 3);
        @(negedge clk);
        size = 4'd7;
        sigma = 3'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (25) @(negedge clk);
        chk("rst_in_fill", 512'(coef_valid), 512'(1));
        #2 n_rst = 1'b0;
        #1;
        chk("rst_busy", 512'(busy), 512'(0));
        chk("rst_done", 512'(done), 512'(0));
        chk("rst_valid", 512'(coef_valid), 512'(0));
        chk("rst_data", 512'(coef_data), 512'(0));
        chk("rst_xy", 512'({coef_x, coef_y}), 512'(0));
        chk("rst_kernel", 512'(kernel), 512'(0));
        chk("rst_sum", 512'(sum), 512'(0));
        chk("rst_ksize", 512'(kernel_size), 512'(0));
        @(negedge clk);
        n_rst = 1'b1;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk("no_done_rst", 512'(seen), 512'(0));
    endtask

    initial begin
        int dc;
        n_rst = 1'b0;
        start = 1'b0;
        size = '0;
        sigma = '0;
        coef_ready = 1'b1;
        #1;
        chk("r_busy", 512'(busy), 512'(0));
        chk("r_done", 512'(done), 512'(0));
        chk("r_valid", 512'(coef_valid), 512'(0));
        chk("r_data", 512'(coef_data), 512'(0));
        chk("r_xy", 512'({coef_x, coef_y}), 512'(0));
        chk("r_kernel", 512'(kernel), 512'(0));
        chk("r_sum", 512'(sum), 512'(0));
        chk("r_ksize", 512'(kernel_size), 512'(0));
        #20;
        @(negedge clk);
        n_rst = 1'b1;

        run(3, 1, 0, 0, dc);
        chk("d3_cycle", 512'(dc), 512'(12));
        chk("d3_corner", 512'(kernel[7:0]), 512'(94));
        chk("d3_edge", 512'(kernel[15:8]), 512'(155));
        chk("d3_centre", 512'(kernel[71:64]), 512'(255));
        chk("d3_corner2", 512'(kernel[135:128]), 512'(94));
        chk("d3_sum", 512'(sum), 512'(1251));
        chk("d3_ksize", 512'(kernel_size), 512'(3));

        run(7, 0, 0, 0, dc);
        chk("s0_centre", 512'(kernel[199:192]), 512'(255));
        run(7, 1, 0, 0, dc);
        chk("s1_centre", 512'(kernel[199:192]), 512'(255));

        run(4, 3, 0, 0, dc);
        chk("clamp4", 512'(kernel_size), 512'(3));
        run(2, 5, 0, 0, dc);
        chk("clamp2", 512'(kernel_size), 512'(3));
        run(15, 7, 0, 0, dc);
        chk("clamp15", 512'(kernel_size), 512'(7));

        run(5, 2, 45, 0, dc);
        run(5, 3, 0, 1, dc);
        run(3, 2, 0, 0, dc);

        reset_mid_fill();
        run(7, 3, 20, 0, dc);

        repeat (8)
            run(int'($urandom_range(15)), int'($urandom_range(7)),
                int'($urandom_range(60)), bit'($urandom_range(1)), dc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
